// File: rtl/rng_arb_pkg.sv
// Shared types and defaults for rng_share_arbiter and its round-robin picker.
package rng_arb_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StSettle = 1'b1
    } arb_state_e;

    localparam int unsigned DEFAULT_N_REQ  = 4;
    localparam int unsigned DEFAULT_WIDTH  = 16;
    localparam int unsigned DEFAULT_STRIDE = 4;

    // Settle counter width; a stride of 1 still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned stride);
        return (stride > 1) ? int'($clog2(stride)) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority selector: first set request at or above ptr, wrapping upward.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] idx
);

    logic              found;
    logic [31:0]       sum;
    logic [IDX_W-1:0]  pos;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        sum    = '0;
        pos    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sum = 32'(ptr) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            pos = IDX_W'(sum);
            if (!found && req[pos]) begin
                found       = 1'b1;
                winner[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/rng_share_arbiter.sv
// Round-robin sharing of the LFSR word among N_REQ consumers.
// Define RNG_ARB_SETTLE_GUARD_EN to enforce STRIDE LFSR shifts between deliveries.
module rng_share_arbiter
    import rng_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = DEFAULT_N_REQ,
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STRIDE = DEFAULT_STRIDE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] rnd_number,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [WIDTH-1:0] rnd_out,
    output logic             rnd_valid,
    output logic             busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic             valid_q, valid_d;
    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             eligible;
    logic             fire;

    rr_picker #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .winner(pick),
        .idx   (pick_idx)
    );

    assign fire = eligible & en & (|req);

`ifdef RNG_ARB_SETTLE_GUARD_EN
    localparam int unsigned          CNT_W    = cnt_width(STRIDE);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STRIDE - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Counter tracks LFSR shifts, so it only moves while enabled.
                if (en) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StSettle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StSettle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign eligible = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
`else
    // STRIDE only matters with the settle guard.
    logic unused_stride;
    assign unused_stride = ^STRIDE;
    assign eligible      = 1'b1;
    assign busy          = 1'b0;
`endif

    always_comb begin
        gnt_d   = '0;
        valid_d = 1'b0;
        rnd_d   = rnd_q;
        ptr_d   = ptr_q;
        if (fire) begin
            gnt_d   = pick;
            valid_d = 1'b1;
            rnd_d   = rnd_number;
            ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            gnt_q   <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_out   = rnd_q;
    assign rnd_valid = valid_q;

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Randomized and directed bench for rng_share_arbiter against a behavioural model.
module tb_rng_share_arbiter;

    localparam int N      = 4;
    localparam int W      = 16;
    localparam int STRIDE = 4;
`ifdef RNG_ARB_SETTLE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int SPACING = GUARD ? STRIDE + 1 : 1;
    localparam int WAIT0   = GUARD ? STRIDE : 0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] rnd_number;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [W-1:0] rnd_out;
    logic         rnd_valid;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: enabled edges still to wait before a grant, rotation pointer, expected outputs.
    int           m_wait;
    int           m_ptr;
    logic [N-1:0] m_gnt;
    logic [W-1:0] m_rnd;
    logic         m_valid;

    rng_share_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .STRIDE(STRIDE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rnd_number(rnd_number),
        .req       (req),
        .gnt       (gnt),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
        return {1'b0, v[W-1:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic void model_reset();
        m_wait  = WAIT0;
        m_ptr   = 0;
        m_gnt   = '0;
        m_valid = 1'b0;
        m_rnd   = '0;
    endfunction

    function automatic void model_edge(input logic en_s, input logic [N-1:0] req_s,
                                       input logic [W-1:0] rnd_s);
        m_gnt   = '0;
        m_valid = 1'b0;
        if (!en_s) return;
        if (m_wait > 0) begin
            m_wait--;
            return;
        end
        for (int k = 0; k < N; k++) begin
            int w;
            w = (m_ptr + k) % N;
            if (req_s[w]) begin
                m_gnt[w] = 1'b1;
                m_valid  = 1'b1;
                m_rnd    = rnd_s;
                m_ptr    = (w + 1) % N;
                m_wait   = WAIT0;
                break;
            end
        end
    endfunction

    task automatic check_outputs(input string ctx);
        check_eq({ctx, ".gnt"}, 32'(gnt), 32'(m_gnt));
        check_eq({ctx, ".valid"}, 32'(rnd_valid), 32'(m_valid));
        check_eq({ctx, ".rnd_out"}, 32'(rnd_out), 32'(m_rnd));
        check_eq({ctx, ".busy"}, 32'(busy), 32'(m_wait > 0));
    endtask

    task automatic step(input string ctx);
        logic         en_s;
        logic [N-1:0] req_s;
        logic [W-1:0] rnd_s;
        en_s  = en;
        req_s = req;
        rnd_s = rnd_number;
        @(posedge clk);
        model_edge(en_s, req_s, rnd_s);
        #1;
        if (en_s) rnd_number = lfsr_next(rnd_number);
        @(negedge clk);
        check_outputs(ctx);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string ctx, input int limit, output int cycles);
        cycles = 0;
        do begin
            step(ctx);
            cycles++;
        end while (!rnd_valid && cycles < limit);
        if (!rnd_valid) check_eq({ctx, ".timeout"}, 32'(rnd_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           total;
        int           same;
        int           seen1;
        logic [N-1:0] exp_seq [5];
        logic [W-1:0] vals [5];

        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n      = 1'b0;
        en         = 1'b0;
        req        = '0;
        rnd_number = 16'hACE1;
        model_reset();
        #3;
        check_outputs("por");

        // First grant after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        req   = 4'b0100;
        wait_grant("first", 20, lat);
        check_eq("first.latency", 32'(lat), 32'(SPACING));
        check_eq("first.gnt_id", 32'(gnt), 32'b0100);

        // Full rotation from a cleared pointer.
        req = 4'b1111;
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            wait_grant("rr", 20, lat);
            check_eq("rr.spacing", 32'(lat), 32'(SPACING));
            check_eq("rr.order", 32'(gnt), 32'(exp_seq[i]));
            vals[i] = rnd_out;
        end
        same = 0;
        for (int i = 0; i < 5; i++)
            for (int j = i + 1; j < 5; j++)
                if (vals[i] == vals[j]) same++;
        check_eq("rr.distinct", 32'(same), 32'd0);

        // Enable dropped for three cycles right after a grant.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("endrop");
            check_eq("endrop.no_gnt", 32'(gnt), 32'd0);
        end
        en = 1'b1;
        wait_grant("endrop", 20, lat);
        total = lat + 3;
        check_eq("endrop.delay", 32'(total), 32'(SPACING + 3));

        // Request raised then withdrawn before it can be served.
        req = '0;
        for (int i = 0; i < SPACING + 1; i++) step("drain");
        en  = 1'b0;
        req = 4'b0010;
        step("withdraw");
        step("withdraw");
        req   = '0;
        en    = 1'b1;
        seen1 = 0;
        for (int i = 0; i < 8; i++) begin
            step("withdraw");
            if (gnt[1]) seen1++;
        end
        check_eq("withdraw.no_gnt1", 32'(seen1), 32'd0);
        check_eq("withdraw.idle", 32'(busy), 32'd0);

        // Reset in the middle of settling, with the pointer left at 2.
        req = 4'b0010;
        wait_grant("ptr2", 20, lat);
        check_eq("ptr2.gnt", 32'(gnt), 32'b0010);
        req = 4'b1111;
        step("ptr2");
        reset_pulse();
        wait_grant("after_rst", 20, lat);
        check_eq("after_rst.gnt", 32'(gnt), 32'b0001);

        // Random traffic with well-behaved and withdrawing requesters.
        for (int s = 0; s < 400; s++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int b = 0; b < N; b++) begin
                if (req[b] && gnt[b]) req[b] = ($urandom_range(0, 1) == 0);
                else if (req[b]) begin
                    if ($urandom_range(0, 15) == 0) req[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) req[b] = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) reset_pulse();
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rng_share_arbiter.md
# rng_share_arbiter

Round-robin arbiter that shares the 16-bit output of the free-running LFSR RNG among several consumers, such as the cookie machine and future game blocks. Each consumer raises a request and receives one fresh random word, together with a one-cycle grant pulse. A settle guard ensures consecutive deliveries are separated by a minimum number of LFSR shifts, so two consumers never get adjacent (highly correlated) words. The block sits between the `lfsr_64bit` instance and its consumers inside the top-level wrapper.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, range 2..8.
- `WIDTH`, 16: width of the random word, equal to the LFSR tap-out width.
- `STRIDE`, 4: number of enabled cycles the LFSR advances between deliveries, minimum 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: design enable, driven from `ena`. Also gates the LFSR.
- `rnd_number`, in, WIDTH: current LFSR output.
- `req`, in, N_REQ: level requests, one bit per consumer.
- `gnt`, out, N_REQ: one-hot grant pulse, one cycle wide.
- `rnd_out`, out, WIDTH: delivered word. Valid while `rnd_valid` is high and held until the next delivery.
- `rnd_valid`, out, 1: one-cycle pulse, coincident with `gnt`.
- `busy`, out, 1: high whenever state is not IDLE.

## Operation
- FSM states: SETTLE and IDLE, plus a registered grant stage. All outputs are registered.
- Reset: state=SETTLE, settle counter=0, round-robin pointer=0. Outputs: `gnt`=0, `rnd_out`=0, `rnd_valid`=0, `busy`=1.
  - Starting in SETTLE moves the LFSR STRIDE shifts past its seed before the first delivery.
- SETTLE:
  - The counter increments only on cycles with `en`=1.
  - When the counter equals STRIDE-1 on an enabled cycle, the next state is IDLE and the counter clears.
- IDLE:
  - If `en`=1 and `|req`, the winner is the first set `req` bit at or after the pointer, searching upward with wrap.
  - On that edge: `gnt` gets the one-hot winner, `rnd_out` gets `rnd_number`, `rnd_valid`=1, pointer becomes (winner+1) mod N_REQ, next state is SETTLE.
  - If `en`=0 or `req`=0, stay in IDLE.
- `gnt` and `rnd_valid` clear on the following edge unconditionally.
- Requests:
  - A requester holds `req` until it sees `gnt`.
  - Dropping `req` before the grant withdraws the request; no grant is issued to it.
  - A requester that keeps `req` high after its grant is served again only after every other active requester has been served (rotating pointer).
- `en`=0 freezes the FSM and counter, matching the frozen LFSR. A grant pulse already registered still completes normally.

## Timing
- Latency: `req` sampled in IDLE at edge k produces `gnt`/`rnd_valid`/`rnd_out` valid after edge k.
- Minimum delivery spacing with `en` held high: STRIDE+1 cycles (STRIDE in SETTLE, 1 in IDLE).
- First possible grant: visible STRIDE+1 enabled cycles after `rst_n` deasserts.
- Reset mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge. Pointer and counter clear.
- `rnd_out` width equals WIDTH, with no truncation or extension.

## Configuration
- `RNG_ARB_SETTLE_GUARD_EN` defined: SETTLE state and counter are present, behaving as described above.
- `RNG_ARB_SETTLE_GUARD_EN` undefined:
  - No SETTLE state; reset state is IDLE.
  - A grant is possible on every enabled cycle, so deliveries can come back-to-back, one LFSR shift apart.
  - `busy` is tied to 0.
  - Arbitration, pointer and handshake rules are unchanged.

## Structure
- Package `rng_arb_pkg` holds:
  - the state enum (IDLE, SETTLE);
  - the default constants for STRIDE, N_REQ and WIDTH;
  - the counter width function `$clog2(STRIDE)`, minimum 1 bit.
- Sub-module `rr_picker`: combinational rotating-priority one-hot selector. Inputs are `req` and the pointer; outputs are the one-hot winner and its index.

## Test plan
- Reset release with `en`=1, STRIDE=4, `req`=4'b0100 held → `gnt`=4'b0100 and `rnd_valid`=1 exactly 5 cycles after `rst_n` rises; `rnd_out` equals `rnd_number` at that sampling edge.
- `req`=4'b1111 held → `gnt` sequence 0001, 0010, 0100, 1000, 0001, spaced 5 cycles apart; all five `rnd_out` values differ.
- `en` dropped for 3 cycles during SETTLE → next grant delayed by exactly 3 cycles; no grant ever issued while `en`=0.
- `req[1]` raised then dropped during SETTLE, before IDLE → no `gnt[1]`; `busy` returns to 0 and `gnt` stays 0.
- `rst_n` pulsed low mid-SETTLE with `gnt` history at pointer=2 → outputs immediately 0; next grant with `req`=4'b1111 goes to requester 0.
- Macro undefined, `req`=4'b1111, `en`=1 → grants rotate every cycle; `rnd_out` follows consecutive LFSR values; `busy` stays 0.
